// File: rtl/drum_pkg.sv
// drum_pkg: shared types and helpers for the one-shot drum voice controllers.
package drum_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, DECAY} ctrl_state_t;

    localparam int unsigned VOLUME_BITS = 4;
    localparam int unsigned VMAX        = (32'd1 << VOLUME_BITS) - 32'd1;

    // Accented notes start at full scale; unaccented ones a quarter of the range lower.
    function automatic int unsigned vol_init(input logic accent, input int unsigned vbits);
        int unsigned vmax;
        vmax = (32'd1 << vbits) - 32'd1;
        return accent ? vmax : vmax - (vmax + 32'd1) / 32'd4;
    endfunction

    // One exponential sweep step toward target; the step never exceeds the distance.
    function automatic logic [31:0] sweep_step(input logic [31:0] cur, input logic [31:0] target,
                                               input int unsigned shift);
        logic [31:0] d;
        logic [31:0] s;
        d = (cur > target) ? cur - target : target - cur;
        s = ((d >> shift) == 32'd0) ? 32'd1 : d >> shift;
        return (d == 32'd0) ? cur : (cur > target) ? cur - s : cur + s;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: free-running divider producing a one-cycle pulse every MCLK_PER_SAMPLE clocks.
module sample_tick_gen #(
    parameter int MCLK_PER_SAMPLE = 256
) (
    input  logic mclk,
    input  logic rst,
    output logic sample_tick
);
    localparam int CW = (MCLK_PER_SAMPLE > 1) ? $clog2(MCLK_PER_SAMPLE) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;
    logic          wrap;

    assign wrap  = cnt_q == CW'(MCLK_PER_SAMPLE - 1);
    assign cnt_d = wrap ? '0 : cnt_q + 1'b1;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= wrap;
        end
    end

    assign sample_tick = tick_q;
endmodule

// File: rtl/oneshot_808_ctrl.sv
// oneshot_808_ctrl: trigger, exponential pitch sweep and hold/linear-decay volume envelope
// for the 808-style one-shot voice.
module oneshot_808_ctrl
    import drum_pkg::*;
#(
    parameter int FREQ_RES_BITS   = 16,
    parameter int VOLUME_BITS     = 4,
    parameter int MCLK_PER_SAMPLE = 256,
    parameter int HOLD_SAMPLES    = 32,
    parameter int SWEEP_SHIFT     = 5
) (
    input  logic                     mclk,
    input  logic                     rst,
    input  logic                     trig,
    input  logic                     accent,
    input  logic [FREQ_RES_BITS-1:0] f_start,
    input  logic [FREQ_RES_BITS-1:0] f_end,
    input  logic [7:0]               decay_rate,
    output logic [FREQ_RES_BITS-1:0] p_frequency,
    output logic [VOLUME_BITS-1:0]   volume,
    output logic                     player_restart,
    output logic                     busy,
    output logic                     sample_tick
);
    localparam int HW = $clog2(HOLD_SAMPLES + 2);

    ctrl_state_t              state_q, state_d;
    logic [FREQ_RES_BITS-1:0] freq_q, freq_d, fend_q, fend_d;
    logic [VOLUME_BITS-1:0]   vol_q, vol_d;
    logic [7:0]               rate_q, rate_d, dec_q, dec_d;
    logic [HW-1:0]            hold_q, hold_d;
    logic                     restart_q, restart_d, busy_q, busy_d;
    logic                     tick;

    sample_tick_gen #(.MCLK_PER_SAMPLE(MCLK_PER_SAMPLE)) u_tick (
        .mclk        (mclk),
        .rst         (rst),
        .sample_tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        freq_d    = freq_q;
        fend_d    = fend_q;
        rate_d    = rate_q;
        vol_d     = vol_q;
        hold_d    = hold_q;
        dec_d     = dec_q;
        restart_d = 1'b0;
        busy_d    = busy_q;
        if (trig) begin
            // A trigger always wins, even over a coincident tick or the final decrement.
            fend_d    = f_end;
            rate_d    = (decay_rate == 8'd0) ? 8'd1 : decay_rate;
            freq_d    = f_start;
            vol_d     = VOLUME_BITS'(vol_init(accent, VOLUME_BITS));
            restart_d = 1'b1;
            hold_d    = '0;
            dec_d     = '0;
            state_d   = (HOLD_SAMPLES == 0) ? DECAY : HOLD;
            busy_d    = 1'b1;
        end else if (tick && state_q != IDLE) begin
            freq_d = FREQ_RES_BITS'(sweep_step(32'(freq_q), 32'(fend_q), SWEEP_SHIFT));
            if (state_q == HOLD) begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HW'(HOLD_SAMPLES - 1)) begin
                    state_d = DECAY;
                    dec_d   = '0;
                end
            end else if (dec_q == rate_q - 8'd1) begin
                dec_d = '0;
                vol_d = vol_q - 1'b1;
                if (vol_q == VOLUME_BITS'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end else begin
                dec_d = dec_q + 8'd1;
            end
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            freq_q    <= '0;
            fend_q    <= '0;
            rate_q    <= '0;
            vol_q     <= '0;
            hold_q    <= '0;
            dec_q     <= '0;
            restart_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            freq_q    <= freq_d;
            fend_q    <= fend_d;
            rate_q    <= rate_d;
            vol_q     <= vol_d;
            hold_q    <= hold_d;
            dec_q     <= dec_d;
            restart_q <= restart_d;
            busy_q    <= busy_d;
        end
    end

    assign p_frequency    = freq_q;
    assign volume         = vol_q;
    assign player_restart = restart_q;
    assign busy           = busy_q;
    assign sample_tick    = tick;
endmodule

// File: tb/tb_oneshot_808_ctrl.sv
// tb_oneshot_808_ctrl: randomized and directed bench with a note-level reference model.
module tb_oneshot_808_ctrl;
    localparam int MPS = 4;
    localparam int HS  = 2;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic        accent = 1'b0;
    logic [15:0] f_start = '0;
    logic [15:0] f_end = '0;
    logic [7:0]  decay_rate = '0;
    logic [15:0] p_frequency;
    logic [3:0]  volume;
    logic        player_restart, busy, sample_tick;

    int tests = 0;
    int fails = 0;

    // Reference model: note age in ticks, envelope derived from age arithmetically.
    int e, m_freq, m_fend, m_rate, m_vinit, m_vol, m_ticks;
    bit m_active, m_restart, m_tick;

    oneshot_808_ctrl #(
        .FREQ_RES_BITS(16), .VOLUME_BITS(4), .MCLK_PER_SAMPLE(MPS),
        .HOLD_SAMPLES(HS), .SWEEP_SHIFT(5)
    ) dut (
        .mclk(mclk), .rst(rst), .trig(trig), .accent(accent), .f_start(f_start),
        .f_end(f_end), .decay_rate(decay_rate), .p_frequency(p_frequency),
        .volume(volume), .player_restart(player_restart), .busy(busy),
        .sample_tick(sample_tick)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        e = 0; m_freq = 0; m_fend = 0; m_rate = 1; m_vinit = 0; m_vol = 0; m_ticks = 0;
        m_active = 0; m_restart = 0; m_tick = 0;
    endtask

    task automatic model_edge(input bit t, input bit a, input int fs, input int fe, input int dr);
        bit tk;
        int d, s, decays;
        tk = m_tick;
        e++;
        m_tick = (e % MPS == 0);
        m_restart = 0;
        if (t) begin
            m_active = 1; m_ticks = 0; m_freq = fs; m_fend = fe;
            m_rate = (dr == 0) ? 1 : dr;
            m_vinit = a ? 15 : 11;
            m_vol = m_vinit; m_restart = 1;
        end else if (tk && m_active) begin
            m_ticks++;
            d = (m_freq > m_fend) ? m_freq - m_fend : m_fend - m_freq;
            s = (d / 32 == 0) ? 1 : d / 32;
            if (d != 0) m_freq = (m_freq > m_fend) ? m_freq - s : m_freq + s;
            decays = (m_ticks > HS) ? (m_ticks - HS) / m_rate : 0;
            m_vol = m_vinit - decays;
            if (m_vol == 0) m_active = 0;
        end
    endtask

    always @(negedge mclk) begin
        if (!rst) begin
            chk("p_frequency", p_frequency, m_freq);
            chk("volume", volume, m_vol);
            chk("player_restart", player_restart, m_restart);
            chk("busy", busy, m_active);
            chk("sample_tick", sample_tick, m_tick);
        end
    end

    task automatic cyc();
        @(posedge mclk);
        model_edge(trig, accent, f_start, f_end, decay_rate);
        @(negedge mclk);
        trig = 1'b0;
    endtask

    task automatic fire(input bit a, input int fs, input int fe, input int dr);
        accent = a; f_start = 16'(fs); f_end = 16'(fe); decay_rate = 8'(dr); trig = 1'b1;
        cyc();
    endtask

    task automatic hard_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_freq", p_frequency, 0);
        chk("rst_vol", volume, 0);
        chk("rst_restart", player_restart, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick", sample_tick, 0);
        model_reset();
        @(negedge mclk);
        @(negedge mclk);
        rst = 1'b0;
    endtask

    // Counts ticks observed while busy until the note ends (bounded).
    task automatic run_note(output int nt, output bit done);
        nt = 0; done = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!busy) begin done = 1; break; end
            nt += int'(sample_tick);
            cyc();
        end
        chk("note_done", done, 1);
    endtask

    initial begin
        int nt, prev, last_step, nchg;
        bit done;
        model_reset();
        @(negedge mclk);
        @(negedge mclk);
        rst = 1'b0;

        nt = 0;
        repeat (100) begin cyc(); nt += int'(sample_tick); end
        chk("idle_ticks", nt, 25);
        fire(1, 1000, 200, 1);
        repeat (5) cyc();
        hard_reset();

        fire(1, 1000, 200, 1);
        chk("s2_restart", player_restart, 1);
        chk("s2_freq", p_frequency, 1000);
        chk("s2_vol", volume, 15);
        chk("s2_busy", busy, 1);
        run_note(nt, done);
        chk("s2_ticks", nt, 17);
        chk("s2_vol_end", volume, 0);

        fire(1, 1000, 200, 255);
        prev = 1000; nchg = 0; last_step = 0;
        repeat (800) begin
            cyc();
            if (int'(p_frequency) != prev) begin
                nchg++;
                if (nchg == 1) chk("down_step1", p_frequency, 975);
                if (nchg == 2) chk("down_step2", p_frequency, 951);
                chk("down_mono", int'(p_frequency) < prev, 1);
                chk("down_floor", p_frequency >= 200, 1);
                last_step = prev - int'(p_frequency);
                prev = int'(p_frequency);
            end
        end
        chk("down_end", p_frequency, 200);
        chk("down_last_step", last_step, 1);

        fire(1, 200, 1000, 255);
        prev = 200; nchg = 0; last_step = 0;
        repeat (800) begin
            cyc();
            if (int'(p_frequency) != prev) begin
                nchg++;
                if (nchg == 1) chk("up_step1", p_frequency, 225);
                if (nchg == 2) chk("up_step2", p_frequency, 249);
                chk("up_mono", int'(p_frequency) > prev, 1);
                chk("up_ceil", p_frequency <= 1000, 1);
                last_step = int'(p_frequency) - prev;
                prev = int'(p_frequency);
            end
        end
        chk("up_end", p_frequency, 1000);
        chk("up_last_step", last_step, 1);

        fire(0, 300, 100, 0);
        chk("s4_vol", volume, 11);
        run_note(nt, done);
        chk("s4_ticks", nt, 13);

        fire(1, 1000, 200, 1);
        done = 0;
        for (int i = 0; i < 400; i++) begin
            if (volume == 4'd7) begin done = 1; break; end
            cyc();
        end
        chk("s5_reach7", done, 1);
        fire(0, 500, 800, 3);
        chk("s5_restart", player_restart, 1);
        chk("s5_vol", volume, 11);
        chk("s5_freq", p_frequency, 500);
        chk("s5_busy", busy, 1);

        fire(0, 3000, 100, 0);
        done = 0;
        for (int i = 0; i < 400; i++) begin
            if (volume == 4'd1 && sample_tick && busy) begin done = 1; break; end
            cyc();
        end
        chk("s6_reach_last", done, 1);
        fire(1, 4000, 100, 0);
        chk("s6_busy", busy, 1);
        chk("s6_vol", volume, 15);
        chk("s6_freq", p_frequency, 4000);
        chk("s6_restart", player_restart, 1);
        run_note(nt, done);
        chk("s6_ticks", nt, 17);

        repeat (3000) begin
            if ($urandom_range(0, 999) == 0) hard_reset();
            else if ($urandom_range(0, 79) == 0)
                fire(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                     int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
            else cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
